// File: rtl/fp_add_core_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract core for normal operands.
// Special results from the upstream classifier bypass the datapath in one cycle.
module fp_add_core_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRS_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   symbol,
  input  logic                   special_flag,
  input  logic [EXP_W+MAN_W:0]   special_in,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done,
  output logic                   busy
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + GRS_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EW-1:0] ONE    = EW'(1);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t                 state, state_next;
  logic [W-1:0]           op_a, op_b;
  logic                   eff_sub, sign_r;
  logic signed [EW-1:0]   exp_r;
  logic [M-1:0]           mant_r, mant_y;

  logic                   a_ge_b;
  logic [W-1:0]           op_x, op_y;
  logic [EXP_W-1:0]       exp_diff;
  logic [M-1:0]           mx, my, my_shift, lost_mask;

  logic                   round_up;
  logic [MAN_W+1:0]       rnd;
  logic signed [EW-1:0]   exp_rnd;
  logic [MAN_W-1:0]       frac_rnd;

  assign busy = (state != IDLE);

  // Alignment: the larger magnitude becomes X; bits of Y shifted out collapse into sticky.
  always_comb begin
    a_ge_b    = op_a[W-2:0] >= op_b[W-2:0];
    op_x      = a_ge_b ? op_a : op_b;
    op_y      = a_ge_b ? op_b : op_a;
    exp_diff  = op_x[W-2:MAN_W] - op_y[W-2:MAN_W];
    mx        = {2'b01, op_x[MAN_W-1:0], {GRS_W{1'b0}}};
    my        = {2'b01, op_y[MAN_W-1:0], {GRS_W{1'b0}}};
    lost_mask = ~({M{1'b1}} << exp_diff);
    if (exp_diff >= EXP_W'(M - 1))
      my_shift = {{(M-1){1'b0}}, 1'b1};
    else
      my_shift = (my >> exp_diff) | {{(M-1){1'b0}}, |(my & lost_mask)};
  end

  always_comb begin
    round_up = mant_r[GRS_W-1] & (mant_r[GRS_W] | (|mant_r[GRS_W-2:0]));
    rnd      = {1'b0, mant_r[M-2:GRS_W]} + (MAN_W+2)'(round_up);
    if (rnd[MAN_W+1]) begin
      frac_rnd = rnd[MAN_W:1];
      exp_rnd  = exp_r + ONE;
    end else begin
      frac_rnd = rnd[MAN_W-1:0];
      exp_rnd  = exp_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = special_flag ? DONE : ALIGN;
      ALIGN: state_next = ADD;
      ADD:   state_next = NORM;
      NORM: begin
        if (mant_r == '0)            state_next = DONE;
        else if (mant_r[M-1])        state_next = ROUND;
        else if (mant_r[M-2])        state_next = ROUND;
        else if (exp_r <= ONE)       state_next = DONE;
        else                         state_next = NORM;
      end
      ROUND: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; the sign of B is folded with symbol when operands are latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      eff_sub <= 1'b0;
      sign_r  <= 1'b0;
      exp_r   <= '0;
      mant_r  <= '0;
      mant_y  <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (special_flag) begin
              result <= special_in;
            end else begin
              op_a    <= a;
              op_b    <= {b[W-1] ^ symbol, b[W-2:0]};
              eff_sub <= a[W-1] ^ b[W-1] ^ symbol;
            end
          end
        end
        ALIGN: begin
          mant_r <= mx;
          mant_y <= my_shift;
          exp_r  <= {{(EW-EXP_W){1'b0}}, op_x[W-2:MAN_W]};
          sign_r <= op_x[W-1];
        end
        ADD: begin
          mant_r <= eff_sub ? (mant_r - mant_y) : (mant_r + mant_y);
        end
        NORM: begin
          if (mant_r == '0) begin
            result <= '0;
          end else if (mant_r[M-1]) begin
            mant_r <= {1'b0, mant_r[M-1:2], mant_r[1] | mant_r[0]};
            exp_r  <= exp_r + ONE;
          end else if (mant_r[M-2]) begin
            mant_r <= mant_r;
          end else if (exp_r <= ONE) begin
            result <= {sign_r, {(W-1){1'b0}}};
          end else begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - ONE;
          end
        end
        ROUND: begin
          if (exp_rnd >= EMAX_S)
            result <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else
            result <= {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_core_seq.sv
// Self-checking bench for fp_add_core_seq: exact-arithmetic reference model,
// per-cycle compare of done/busy/result, directed vectors plus random operands.
module tb_fp_add_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0, special_in = '0;
  logic        symbol = 1'b0, special_flag = 1'b0;
  logic [31:0] result;
  logic        done, busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  bit          exp_active = 1'b0;
  int          exp_start = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_result = '0;

  fp_add_core_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .symbol(symbol),
    .special_flag(special_flag), .special_in(special_in),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Exact rational sum rounded to nearest-even, subnormals flushed, plus expected latency.
  function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic sym,
                                output logic [31:0] res, output int lat);
    logic [31:0]  bb, x, y;
    logic [127:0] sx, sy, s, q, rem, half;
    logic         sub, up;
    int           ex, ey, d, p, epre, e, k, sh;
    bb = {bv[31] ^ sym, bv[30:0]};
    if (av[30:0] >= bb[30:0]) begin x = av; y = bb; end
    else                       begin x = bb; y = av; end
    sub = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    d  = ex - ey;
    if (d > 40) begin
      res = x;
      lat = (sub && x[22:0] == 23'd0) ? 6 : 5;
      return;
    end
    sx = 128'(x[22:0]) | (128'd1 << 23);
    sy = 128'(y[22:0]) | (128'd1 << 23);
    s  = sub ? ((sx << d) - sy) : ((sx << d) + sy);
    if (s == 128'd0) begin
      res = 32'h0;
      lat = 4;
      return;
    end
    p = 0;
    for (int i = 127; i >= 0; i--) if (s[i]) begin p = i; break; end
    epre = ey + p - 23;
    if (epre <= 0) begin
      res = {x[31], 31'h0};
      lat = ex + 3;
      return;
    end
    k   = (ex > epre) ? ex - epre : 0;
    lat = 5 + k;
    e   = epre;
    if (p > 23) begin
      sh   = p - 23;
      q    = s >> sh;
      rem  = s & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && q[0]);
      q    = q + 128'(up);
      if (q[24]) begin q = q >> 1; e = e + 1; end
    end else begin
      q = s << (23 - p);
    end
    if (e >= 255) res = {x[31], 8'hFF, 23'h0};
    else          res = {x[31], 8'(e), q[22:0]};
  endfunction

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_active) begin
        if (cyc < exp_start + exp_lat) begin
          checkOutput("busy_inflight", 32'(busy), 32'd1);
          checkOutput("done_early", 32'(done), 32'd0);
        end else begin
          checkOutput("done_pulse", 32'(done), 32'd1);
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          checkOutput("result", result, exp_res);
          last_result = exp_res;
          exp_active  = 1'b0;
        end
      end else begin
        checkOutput("done_idle", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("result_hold", result, last_result);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sym,
                               input logic flag, input logic [31:0] spec,
                               input logic [31:0] res, input int lat);
    @(negedge clk);
    a = av; b = bv; symbol = sym; special_flag = flag; special_in = spec;
    start      = 1'b1;
    exp_res    = res;
    exp_lat    = lat;
    exp_start  = cyc + 1;
    exp_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 400 && exp_active; i++) @(negedge clk);
    if (exp_active) begin
      tests_failed++;
      $display("[TB] FAIL timeout: done not seen, expected latency %0d", exp_lat);
      exp_active = 1'b0;
    end
  endtask

  task automatic checkModel(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic sym, input logic [31:0] res, input int lat);
    logic [31:0] r;
    int l;
    model(av, bv, sym, r, l);
    checkOutput({name, "_model_res"}, r, res);
    checkOutput({name, "_model_lat"}, 32'(l), 32'(lat));
  endtask

  task automatic runVec(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic sym, input logic [31:0] res, input int lat);
    checkModel(name, av, bv, sym, res, lat);
    applyStimulus(av, bv, sym, 1'b0, 32'h0, res, lat);
    waitIdle();
  endtask

  function automatic logic [31:0] randOperand(input int near_exp);
    int e, r;
    r = int'($urandom_range(0, 9));
    if (near_exp > 0) begin
      e = near_exp + int'($urandom_range(0, 6)) - 3;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else if (r == 0) e = int'($urandom_range(1, 4));
    else if (r == 1)     e = int'($urandom_range(250, 254));
    else                 e = int'($urandom_range(1, 254));
    return {1'($urandom), 8'(e), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] ra, rb, rr;
    int          rl;
    logic        rs;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    runVec("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5);
    runVec("sub_k2",       32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 7);
    runVec("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5);
    runVec("tie_odd",      32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 5);
    runVec("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5);
    runVec("cancel",       32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4);
    runVec("flush",        32'h00C00000, 32'h00A00000, 1'b1, 32'h00000000, 4);

    applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 32'hFFC00001, 32'hFFC00001, 1);
    waitIdle();

    // A second start while busy must not produce another done pulse.
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h0, 32'h40000000, 5);
    special_flag = 1'b1; special_in = 32'h12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0; special_flag = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);

    // Reset while in NORM aborts with no done pulse.
    applyStimulus(32'h3FC00000, 32'h3FA00000, 1'b1, 1'b0, 32'h0, 32'h3E800000, 7);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_active  = 1'b0;
    last_result = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runVec("after_reset", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 5);

    for (int n = 0; n < 150; n++) begin
      ra = randOperand(0);
      rb = ($urandom_range(0, 1) == 1) ? randOperand(int'(ra[30:23])) : randOperand(0);
      if ($urandom_range(0, 15) == 0) rb = ra;
      rs = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rr = $urandom;
        applyStimulus(ra, rb, rs, 1'b1, rr, rr, 1);
      end else begin
        model(ra, rb, rs, rr, rl);
        applyStimulus(ra, rb, rs, 1'b0, 32'h0, rr, rl);
      end
      waitIdle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fp_add_core_seq.md
Name: fp_add_core_seq

Overview:
- Multi-cycle IEEE-754 single-precision add/subtract datapath for normal operands.
- Sits directly downstream of the special-value classifier/adder stage and consumes its `out`/`check_special` pair.
- When the special flag is set, the block forwards the special result with 1-cycle latency.
- Otherwise it aligns, adds, normalises iteratively and rounds (round-to-nearest-even), then emits one result with a one-cycle done pulse.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 23, stored fraction width
- GRS_W, 3, guard/round/sticky bits carried through the datapath

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  32  operand A
- b  input  32  operand B
- symbol  input  1  0 = A+B, 1 = A−B
- special_flag  input  1  check_special from the special-value stage, aligned with start
- special_in  input  32  special-case result from the same stage
- result  output  32  final sum/difference
- done  output  1  one-cycle pulse when result is valid
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; result=0, done=0, busy=0; all internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- Internal mantissa register is 28 bits: [27] carry, [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky.
- Exponent arithmetic is 10-bit signed to detect overflow and underflow.
- Effective subtract: eff_sub = a[31] ^ b[31] ^ symbol.

States and transitions:
- IDLE: on start=1 with special_flag=1, latch result=special_in and go to DONE. On start=1 with special_flag=0, latch operands and go to ALIGN. start is ignored in every other state.
- ALIGN: swap operands so that |X| >= |Y|, comparing {exp, frac}. Result sign = sign of X, where the sign of B is taken as b[31]^symbol. Shift Y right by d = expX−expY; bits shifted out OR into sticky. If d >= 27, Y becomes sticky only. Next state ADD.
- ADD: mant = mantX ± mantY per eff_sub; exp = expX. Next state NORM.
- NORM, evaluated one step per cycle:
  - mant==0: result=+0 (0x00000000), go to DONE.
  - mant[27]=1: shift right 1 (sticky preserved), exp+1, go to ROUND.
  - mant[26]=1: go to ROUND.
  - otherwise: shift left 1, exp−1, stay in NORM.
  - If exp reaches 0: flush to signed zero, go to DONE.
- ROUND (RNE): increment when G & (R | S | LSB). If the increment carries out of the hidden bit, shift right 1 and exp+1. If exp >= 255: result = {sign, 0x7F800000[30:0]}. Otherwise pack the result. Next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE.
- result holds its value until the next accepted start; it is never cleared by done falling.

Latency, from the start-sampling edge to the done-high cycle:
- Special bypass: 1 cycle.
- Normal path: 5 cycles + k, where k = number of left-shift NORM cycles.

Subnormal handling:
- Subnormal inputs never reach this block: the upstream stage classifies them as special.
- Subnormal results are flushed to zero.

Test Plan:
- a=0x3F800000, b=0x3F800000, symbol=0, flag=0 -> result=0x40000000; done exactly 5 cycles after start; busy high for 5 cycles.
- a=0x3FC00000, b=0x3FA00000, symbol=1 (1.5−1.25) -> result=0x3E800000; done after 7 cycles (k=2).
- Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie, even, no increment); 0x3F800000+0x34400000 -> 0x3F800002 (tie, odd LSB, round up).
- Boundaries: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 (overflow to +inf). 0x40490FDB−0x40490FDB -> 0x00000000 via the mant==0 path, latency 4.
- Special bypass and handshake:
  - flag=1, special_in=0xFFC00001 -> result=0xFFC00001, done 1 cycle after start.
  - A start pulse asserted while busy is ignored: exactly one done pulse occurs.
  - Asserting rst during NORM -> result=0, busy=0, no done pulse; a subsequent start completes normally.
